// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequenced 16x16 multiplier.
//   state_t   : controller states IDLE / MUL / DONE
//   S_*       : step codes selecting which operand halves feed the 8x8 unit
//   OP_W      : operand width (16), HALF_W: half-operand width (8)
//   pp_shift  : left shift applied to the partial product of each step
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OP_W   = 16;
    localparam int HALF_W = 8;

    localparam logic [1:0] S_LL = 2'd0;
    localparam logic [1:0] S_HL = 2'd1;
    localparam logic [1:0] S_LH = 2'd2;
    localparam logic [1:0] S_HH = 2'd3;

    // Shift table {0, 8, 8, 16} indexed by step.
    function automatic logic [4:0] pp_shift(input logic [1:0] step);
        case (step)
            S_LL:    pp_shift = 5'd0;
            S_HL:    pp_shift = 5'd8;
            S_LH:    pp_shift = 5'd8;
            default: pp_shift = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mul16_seq_ctrl_pp.sv
// Combinational 8x8 unsigned partial-product multiplier.
//   a, b : 8-bit unsigned operands
//   p    : 16-bit unsigned product a*b
module mul16_seq_ctrl_pp
    import mul_seq_pkg::*;
(
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    assign p = (2*HALF_W)'(a) * (2*HALF_W)'(b);

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Sequenced 16x16 unsigned multiplier: one 8x8 partial-product unit is
// time-shared over four cycles; the partial products are summed into a
// 32-bit accumulator.
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : synchronous abort of any operation in flight
//   in_valid/in_ready    : operand channel (in_a, in_b unsigned 16-bit)
//   out_valid/out_ready  : result channel (out_prod = (a*b)[RES_W-1:0])
//   busy                 : high in MUL or DONE
// Parameters:
//   ZERO_SKIP : 1 = a zero operand goes straight to DONE with product 0
//   RES_W     : 32 = full product, 16 = low half only
module mul16_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int ZERO_SKIP = 1,
    parameter int RES_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_prod,
    output logic             busy
);

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          step_q;
    logic [2*OP_W-1:0]   acc_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;

    logic [HALF_W-1:0]   pp_a;
    logic [HALF_W-1:0]   pp_b;
    logic [2*HALF_W-1:0] pp;
    logic [2*OP_W-1:0]   pp_ext;
    logic                accept;
    logic                zero_ops;

    // rst_n gates in_ready so nothing is offered acceptance while in reset.
    assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready & ~flush;
    assign zero_ops = (ZERO_SKIP != 0) && ((in_a == '0) || (in_b == '0));

    assign out_valid = (state_q == DONE);
    assign out_prod  = acc_q[RES_W-1:0];
    assign busy      = (state_q != IDLE);

    // Operand halves for the current step.
    always_comb begin
        pp_a = a_q[HALF_W-1:0];
        pp_b = b_q[HALF_W-1:0];
        case (step_q)
            S_HL: pp_a = a_q[OP_W-1:HALF_W];
            S_LH: pp_b = b_q[OP_W-1:HALF_W];
            S_HH: begin
                pp_a = a_q[OP_W-1:HALF_W];
                pp_b = b_q[OP_W-1:HALF_W];
            end
            default: ;
        endcase
    end

    mul16_seq_ctrl_pp u_pp (
        .a (pp_a),
        .b (pp_b),
        .p (pp)
    );

    assign pp_ext = {{(2*OP_W-2*HALF_W){1'b0}}, pp} << pp_shift(step_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = zero_ops ? DONE : MUL;
            MUL:  if (step_q == S_HH) state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    if (accept) state_d = zero_ops ? DONE : MUL;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over every other transition.
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                acc_q  <= '0;
                step_q <= '0;
            end else if ((state_q == MUL) && !flush) begin
                // Sum cannot exceed 32 bits: it is at most 0xFFFF*0xFFFF.
                acc_q  <= acc_q + pp_ext;
                step_q <= step_q + 2'd1;
            end
        end
    end

endmodule
